// File: rtl/tdr_pkg.sv
// rtl/tdr_pkg.sv - shared state encoding and default widths for the TDR capture sequencer
// Purpose: one place for the acquisition state encoding and the default widths
//          used by tdr_capture_ctrl and tdr_peak_tracker.
// Ports:   none (package).
package tdr_pkg;

  localparam int TDR_ADDR_W = 9;   // capture RAM address width (512 entries)
  localparam int TDR_DATA_W = 8;   // AD sample width
  localparam int TDR_DLY_W  = 16;  // blanking-delay counter width
  localparam int TDR_PLS_W  = 8;   // probe-pulse length counter width

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PULSE   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } tdr_state_e;

endpackage

// File: rtl/tdr_peak_tracker.sv
// rtl/tdr_peak_tracker.sv - running maximum of captured samples with first-occurrence address
// Purpose: tracks the largest sample written during a capture and the address
//          where it first appeared. Strict compare keeps the earliest address on ties.
// Ports:   clk_30M, sys_rst_n (async, active-low)
//          clear            - restart tracking at 0/0 (entering CAPTURE)
//          valid            - sample/addr are a real RAM write this cycle
//          sample, addr     - the write data and its address
//          peak_val, peak_addr - current maximum and its first address
module tdr_peak_tracker
  import tdr_pkg::*;
#(
  parameter int ADDR_W = TDR_ADDR_W,
  parameter int DATA_W = TDR_DATA_W
) (
  input  logic              clk_30M,
  input  logic              sys_rst_n,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] peak_val,
  output logic [ADDR_W-1:0] peak_addr
);

  always_ff @(posedge clk_30M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      peak_val  <= '0;
      peak_addr <= '0;
    end else if (clear) begin
      peak_val  <= '0;
      peak_addr <= '0;
    end else if (valid && (sample > peak_val)) begin
      peak_val  <= sample;
      peak_addr <= addr;
    end
  end

endmodule

// File: rtl/tdr_capture_ctrl.sv
// rtl/tdr_capture_ctrl.sv - TDR acquisition sequencer: probe pulse, blanking delay, sample capture
// Purpose: fires the probe pulse, waits the blanking delay, streams AD samples into
//          the capture RAM at addresses 0..cfg_last, tracks the echo peak, then
//          lends the RAM port to the readout side.
// Ports:   clk_30M, sys_rst_n (async, active-low)
//          start, abort                 - acquisition control (abort wins)
//          cfg_pls_len/cfg_delay/cfg_last - shadowed on an accepted start
//          ad_data                      - AD sample, valid every clock
//          rd_en, rd_addr               - readout access to the RAM port
//          probe_out                    - pulse driver enable
//          ram_we, ram_addr, ram_wdata  - capture RAM port
//          rd_grant                     - rd_addr currently drives ram_addr
//          busy, done                   - acquisition status
//          peak_val, peak_addr          - peak of the last capture
module tdr_capture_ctrl
  import tdr_pkg::*;
#(
  parameter int ADDR_W = TDR_ADDR_W,
  parameter int DATA_W = TDR_DATA_W,
  parameter int DLY_W  = TDR_DLY_W,
  parameter int PLS_W  = TDR_PLS_W
) (
  input  logic              clk_30M,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [PLS_W-1:0]  cfg_pls_len,
  input  logic [DLY_W-1:0]  cfg_delay,
  input  logic [ADDR_W-1:0] cfg_last,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              probe_out,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              rd_grant,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] peak_val,
  output logic [ADDR_W-1:0] peak_addr
);

  tdr_state_e        state;
  logic [PLS_W-1:0]  pls_sh;
  logic [DLY_W-1:0]  dly_sh;
  logic [ADDR_W-1:0] last_sh;
  logic [DLY_W-1:0]  cnt;      // shared by PULSE and DELAY, counts up from 0
  logic [ADDR_W-1:0] wr_cnt;
  logic [DATA_W-1:0] samp_q;

  logic [PLS_W-1:0]  pls_last;
  logic              pulse_end;
  logic              delay_end;
  logic              cap_enter;

  // Pulse length 0 behaves as 1, so the final count index is len-1 clamped at 0.
  always_comb begin
    pls_last  = (pls_sh == '0) ? '0 : (pls_sh - PLS_W'(1));
    pulse_end = (state == ST_PULSE) && (cnt == DLY_W'(pls_last));
    delay_end = (state == ST_DELAY) && (cnt == (dly_sh - DLY_W'(1)));
    cap_enter = !abort && ((pulse_end && (dly_sh == '0)) || delay_end);
  end

  always_ff @(posedge clk_30M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      pls_sh    <= '0;
      dly_sh    <= '0;
      last_sh   <= '0;
      cnt       <= '0;
      wr_cnt    <= '0;
      samp_q    <= '0;
      probe_out <= 1'b0;
      ram_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      samp_q <= ad_data;
      if (abort) begin
        state     <= ST_IDLE;
        probe_out <= 1'b0;
        ram_we    <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              pls_sh    <= cfg_pls_len;
              dly_sh    <= cfg_delay;
              last_sh   <= cfg_last;
              cnt       <= '0;
              state     <= ST_PULSE;
              probe_out <= 1'b1;
              busy      <= 1'b1;
              done      <= 1'b0;
            end
          end
          ST_PULSE: begin
            if (pulse_end) begin
              probe_out <= 1'b0;
              cnt       <= '0;
              if (dly_sh == '0) begin
                state  <= ST_CAPTURE;
                ram_we <= 1'b1;
                wr_cnt <= '0;
              end else begin
                state <= ST_DELAY;
              end
            end else begin
              cnt <= cnt + DLY_W'(1);
            end
          end
          ST_DELAY: begin
            if (delay_end) begin
              state  <= ST_CAPTURE;
              ram_we <= 1'b1;
              wr_cnt <= '0;
            end else begin
              cnt <= cnt + DLY_W'(1);
            end
          end
          ST_CAPTURE: begin
            // Stop after the last address; the counter never wraps.
            if (wr_cnt == last_sh) begin
              state  <= ST_DONE;
              ram_we <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + ADDR_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Readout only gets the port while no acquisition is running.
  always_comb begin
    rd_grant  = rd_en && ((state == ST_IDLE) || (state == ST_DONE));
    ram_addr  = rd_grant ? rd_addr : wr_cnt;
    ram_wdata = samp_q;
  end

  tdr_peak_tracker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_peak (
    .clk_30M   (clk_30M),
    .sys_rst_n (sys_rst_n),
    .clear     (cap_enter),
    .valid     (ram_we),
    .sample    (samp_q),
    .addr      (wr_cnt),
    .peak_val  (peak_val),
    .peak_addr (peak_addr)
  );

endmodule
